eight_to_three_irq: RTL and testbench

EIGHT_TO_THREE_IRQ -- requirements
Module: eight_to_three_irq

---
 rtl/eight_to_three_irq_pkg.sv | 18 +
 rtl/sync_ffn.sv | 32 +++
 rtl/eight_to_three_irq.sv | 132 +++++++++++++
 tb/tb_eight_to_three_irq.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eight_to_three_irq_pkg.sv
// -----------------------------------------------------------------------------
// eight_to_three_irq_pkg
// Shared constants and FSM state encoding for the 8-to-3 interrupt encoder.
//   N_LINES : number of request lines
//   CODE_W  : width of the presented line index
//   state_t : presentation FSM state (IDLE = 0, PRESENT = 1)
// -----------------------------------------------------------------------------
package eight_to_three_irq_pkg;

    localparam int N_LINES = 8;
    localparam int CODE_W  = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/sync_ffn.sv
// -----------------------------------------------------------------------------
// sync_ffn
// Single-bit N-flop synchronizer for an asynchronous input. Every stage
// resets to 1 so an active-low request line reads as idle after reset.
// Ports:
//   clk : sampling clock
//   rst : asynchronous active-high reset (stages forced to 1)
//   d   : asynchronous input
//   q   : synchronized output (last stage)
// -----------------------------------------------------------------------------
module sync_ffn #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '1;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/eight_to_three_irq.sv
// -----------------------------------------------------------------------------
// eight_to_three_irq
// Edge-triggered 8-line priority interrupt encoder with a present/acknowledge
// handshake and a cascade enable output.
//
// Ports:
//   CLK   : clock, all state updates on the rising edge
//   RST   : asynchronous active-high reset
//   IN_N  : asynchronous active-low request lines, bit 7 highest priority
//   EIN   : active-low enable; while high nothing new is presented
//   ACK   : acknowledge of the presented code
//   A,B,C : registered index of the presented line (A = MSB)
//   VALID : registered, high while A/B/C carries a presented code
//   EON   : registered active-low cascade enable for a lower-priority encoder
//   PEND  : registered pending-request bits
//
// Handshake: a code is presented by raising VALID with A/B/C on the same edge.
// A/B/C stay frozen while VALID is high. The code is retired on the first
// rising edge where VALID and ACK are both high; VALID then drops for at least
// one cycle before the next code. ACK while VALID is low has no effect.
//
// SYNC_STAGES must be 2 or 3.
// -----------------------------------------------------------------------------
module eight_to_three_irq
    import eight_to_three_irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [N_LINES-1:0]  IN_N,
    input  logic                EIN,
    input  logic                ACK,
    output logic                A,
    output logic                B,
    output logic                C,
    output logic                VALID,
    output logic                EON,
    output logic [N_LINES-1:0]  PEND
);

    state_t              state;
    logic [CODE_W-1:0]   code_q;
    logic                valid_q;
    logic                eon_q;
    logic [N_LINES-1:0]  pend_q;

    logic [N_LINES-1:0]  synced;
    logic [N_LINES-1:0]  prev_synced;
    logic [N_LINES-1:0]  fall;
    logic [N_LINES-1:0]  clear_mask;
    logic [CODE_W-1:0]   top_idx;

    // One synchronizer per request line.
    for (genvar i = 0; i < N_LINES; i++) begin : g_sync
        sync_ffn #(
            .DEPTH (SYNC_STAGES)
        ) u_sync (
            .clk (CLK),
            .rst (RST),
            .d   (IN_N[i]),
            .q   (synced[i])
        );
    end

    // A request is the high-to-low transition only, so a line held low
    // produces a single request.
    assign fall = prev_synced & ~synced;

    // Index of the highest-priority pending line. Ascending scan so the last
    // set bit found (the highest index) wins.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < N_LINES; i++) begin
            if (pend_q[i]) begin
                top_idx = CODE_W'(i);
            end
        end
    end

    // Bit retired by an acknowledge of the presented code.
    always_comb begin
        clear_mask = '0;
        if (state == PRESENT && ACK) begin
            clear_mask[code_q] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            code_q      <= '0;
            valid_q     <= 1'b0;
            eon_q       <= 1'b1;
            pend_q      <= '0;
            prev_synced <= '1;
        end else begin
            prev_synced <= synced;
            // Clear applied before set: a fresh edge on the bit being
            // acknowledged keeps it pending.
            pend_q      <= (pend_q & ~clear_mask) | fall;
            // Cascade enable is low only when this encoder is enabled and has
            // nothing pending or presented.
            eon_q       <= ~(~EIN & ~(|pend_q) & ~valid_q);

            case (state)
                IDLE: begin
                    if (!EIN && (|pend_q)) begin
                        code_q  <= top_idx;
                        valid_q <= 1'b1;
                        state   <= PRESENT;
                    end
                end
                PRESENT: begin
                    // Code is frozen here; only ACK moves the FSM.
                    if (ACK) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

    assign A     = code_q[2];
    assign B     = code_q[1];
    assign C     = code_q[0];
    assign VALID = valid_q;
    assign EON   = eon_q;
    assign PEND  = pend_q;

endmodule

// File: tb/tb_eight_to_three_irq.sv
module tb_eight_to_three_irq;

    localparam int S = 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] IN_N;
    logic       EIN;
    logic       ACK;
    logic       A, B, C, VALID, EON;
    logic [7:0] PEND;
    logic [2:0] code;

    assign code = {A, B, C};

    eight_to_three_irq #(
        .SYNC_STAGES (S)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .IN_N  (IN_N),
        .EIN   (EIN),
        .ACK   (ACK),
        .A     (A),
        .B     (B),
        .C     (C),
        .VALID (VALID),
        .EON   (EON),
        .PEND  (PEND)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    // samp_q holds the IN_N values sampled at the last S+1 edges (oldest first).
    // A request is seen S edges after the sampled high-to-low transition.
    logic [7:0] samp_q[$];
    logic [7:0] m_pend;
    logic       m_valid;
    logic [2:0] m_code;
    logic       m_eon;

    task automatic model_reset();
        samp_q.delete();
        for (int i = 0; i <= S; i++) samp_q.push_back(8'hFF);
        m_pend  = 8'h00;
        m_valid = 1'b0;
        m_code  = 3'd0;
        m_eon   = 1'b1;
    endtask

    task automatic model_edge();
        logic [7:0] fall;
        logic [7:0] clr;
        int         top;
        samp_q.push_back(IN_N);
        fall = samp_q[0] & ~samp_q[1];
        void'(samp_q.pop_front());
        clr   = 8'h00;
        m_eon = !(!EIN && m_pend == 8'h00 && !m_valid);
        if (!m_valid) begin
            if (!EIN && m_pend != 8'h00) begin
                top = 0;
                for (int i = 0; i < 8; i++) if (m_pend[i]) top = i;
                m_code  = 3'(top);
                m_valid = 1'b1;
            end
        end else if (ACK) begin
            clr     = 8'h01 << m_code;
            m_valid = 1'b0;
        end
        m_pend = (m_pend & ~clr) | fall;
    endtask

    // ---------------- driver ----------------
    // Advance one clock; inputs change only 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        if (RST) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        n_checks++;
        if (VALID !== 1'b0 || code !== 3'b000 || EON !== 1'b1 || PEND !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_vals: got valid=%b code=%b eon=%b pend=%h want 0 000 1 00", VALID, code, EON, PEND);
        end
        ticks(2);
        RST = 1'b0;
        tick();
        n_checks++;
        if (EON !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_eon_idle: got %b want 0", EON);
        end
    endtask

    task automatic test_single();
        IN_N = 8'hDF;
        ticks(2);
        n_checks++;
        if (PEND !== 8'h00) begin
            n_fail++;
            $display("FAIL single_pend_early: got %h want 00", PEND);
        end
        tick();
        n_checks++;
        if (PEND !== 8'h20 || VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pend: got pend=%h valid=%b want 20 0", PEND, VALID);
        end
        tick();
        n_checks++;
        if (VALID !== 1'b1 || code !== 3'b101) begin
            n_fail++;
            $display("FAIL single_present: got valid=%b code=%b want 1 101", VALID, code);
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        n_checks++;
        if (VALID !== 1'b0 || PEND !== 8'h00) begin
            n_fail++;
            $display("FAIL single_ack: got valid=%b pend=%h want 0 00", VALID, PEND);
        end
        IN_N = 8'hFF;
        ticks(3);
    endtask

    task automatic test_priority();
        IN_N = 8'hBD;
        ticks(3);
        n_checks++;
        if (PEND !== 8'h42) begin
            n_fail++;
            $display("FAIL prio_pend: got %h want 42", PEND);
        end
        tick();
        n_checks++;
        if (VALID !== 1'b1 || code !== 3'b110) begin
            n_fail++;
            $display("FAIL prio_first: got valid=%b code=%b want 1 110", VALID, code);
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        n_checks++;
        if (VALID !== 1'b0 || PEND !== 8'h02) begin
            n_fail++;
            $display("FAIL prio_gap: got valid=%b pend=%h want 0 02", VALID, PEND);
        end
        tick();
        n_checks++;
        if (VALID !== 1'b1 || code !== 3'b001) begin
            n_fail++;
            $display("FAIL prio_second: got valid=%b code=%b want 1 001", VALID, code);
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        tick();
        n_checks++;
        if (EON !== 1'b0 || VALID !== 1'b0 || PEND !== 8'h00) begin
            n_fail++;
            $display("FAIL prio_eon: got eon=%b valid=%b pend=%h want 0 0 00", EON, VALID, PEND);
        end
        IN_N = 8'hFF;
        ticks(3);
    endtask

    task automatic test_preempt();
        IN_N = 8'hFB;
        ticks(4);
        IN_N = 8'h7B;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (VALID !== 1'b1 || code !== 3'b010) begin
                n_fail++;
                $display("FAIL preempt_hold: got valid=%b code=%b want 1 010", VALID, code);
            end
        end
        n_checks++;
        if (PEND !== 8'h84) begin
            n_fail++;
            $display("FAIL preempt_pend: got %h want 84", PEND);
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        tick();
        n_checks++;
        if (VALID !== 1'b1 || code !== 3'b111) begin
            n_fail++;
            $display("FAIL preempt_next: got valid=%b code=%b want 1 111", VALID, code);
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        IN_N = 8'hFF;
        ticks(3);
    endtask

    task automatic test_enable();
        EIN  = 1'b1;
        IN_N = 8'hF7;
        ticks(2);
        ACK = 1'b1;
        ticks(2);
        ACK = 1'b0;
        n_checks++;
        if (PEND !== 8'h08 || VALID !== 1'b0 || EON !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_hold: got pend=%h valid=%b eon=%b want 08 0 1", PEND, VALID, EON);
        end
        EIN = 1'b0;
        tick();
        n_checks++;
        if (VALID !== 1'b1 || code !== 3'b011) begin
            n_fail++;
            $display("FAIL enable_present: got valid=%b code=%b want 1 011", VALID, code);
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        IN_N = 8'hFF;
        ticks(3);
    endtask

    task automatic test_collision();
        IN_N = 8'hEF;
        ticks(4);
        IN_N = 8'hFF;
        tick();
        IN_N = 8'hEF;
        ticks(2);
        n_checks++;
        if (VALID !== 1'b1 || code !== 3'b100) begin
            n_fail++;
            $display("FAIL coll_present: got valid=%b code=%b want 1 100", VALID, code);
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        n_checks++;
        if (PEND !== 8'h10 || VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_setwins: got pend=%h valid=%b want 10 0", PEND, VALID);
        end
        tick();
        n_checks++;
        if (VALID !== 1'b1 || code !== 3'b100) begin
            n_fail++;
            $display("FAIL coll_represent: got valid=%b code=%b want 1 100", VALID, code);
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        IN_N = 8'hFF;
        ticks(3);
    endtask

    task automatic test_reset_mid();
        IN_N = 8'hBB;
        ticks(4);
        n_checks++;
        if (VALID !== 1'b1 || code !== 3'b110 || PEND !== 8'h44) begin
            n_fail++;
            $display("FAIL rstmid_pre: got valid=%b code=%b pend=%h want 1 110 44", VALID, code, PEND);
        end
        #3;
        RST = 1'b1;
        #1;
        n_checks++;
        if (VALID !== 1'b0 || code !== 3'b000 || EON !== 1'b1 || PEND !== 8'h00) begin
            n_fail++;
            $display("FAIL rstmid_async: got valid=%b code=%b eon=%b pend=%h want 0 000 1 00", VALID, code, EON, PEND);
        end
        IN_N = 8'hFF;
        ticks(2);
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (VALID !== 1'b0 || PEND !== 8'h00) begin
                n_fail++;
                $display("FAIL rstmid_after: got valid=%b pend=%h want 0 00", VALID, PEND);
            end
        end
    endtask

    task automatic test_low_at_release();
        #2;
        RST  = 1'b1;
        IN_N = 8'hFE;
        ticks(2);
        RST = 1'b0;
        ticks(2);
        n_checks++;
        if (PEND !== 8'h00) begin
            n_fail++;
            $display("FAIL release_early: got %h want 00", PEND);
        end
        tick();
        n_checks++;
        if (PEND !== 8'h01) begin
            n_fail++;
            $display("FAIL release_edge: got %h want 01", PEND);
        end
        tick();
        n_checks++;
        if (VALID !== 1'b1 || code !== 3'b000) begin
            n_fail++;
            $display("FAIL release_present: got valid=%b code=%b want 1 000", VALID, code);
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        IN_N = 8'hFF;
        ticks(3);
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            IN_N = IN_N ^ (8'($urandom) & 8'($urandom));
            EIN  = ($urandom_range(0, 4) == 0);
            ACK  = ($urandom_range(0, 2) == 0);
            RST  = ($urandom_range(0, 199) == 0);
            tick();
            n_checks++;
            if (PEND !== m_pend) begin
                n_fail++;
                $display("FAIL rand_pend cyc %0d: got %h want %h", n, PEND, m_pend);
            end
            n_checks++;
            if (VALID !== m_valid) begin
                n_fail++;
                $display("FAIL rand_valid cyc %0d: got %b want %b", n, VALID, m_valid);
            end
            n_checks++;
            if (code !== m_code) begin
                n_fail++;
                $display("FAIL rand_code cyc %0d: got %b want %b", n, code, m_code);
            end
            n_checks++;
            if (EON !== m_eon) begin
                n_fail++;
                $display("FAIL rand_eon cyc %0d: got %b want %b", n, EON, m_eon);
            end
        end
        RST = 1'b0;
        ACK = 1'b0;
        EIN = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        RST  = 1'b1;
        IN_N = 8'hFF;
        EIN  = 1'b0;
        ACK  = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_priority();
        test_preempt();
        test_enable();
        test_collision();
        test_reset_mid();
        test_low_at_release();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
